// File: rtl/q8_24_divider.sv
// Signed Q8.24 fixed-point divider: restoring division on magnitudes,
// one quotient bit per cycle, then sign, truncation and saturation.
module q8_24_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  localparam logic [N-1:0] POS_LIM =
    {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIM = POS_LIM + 1'b1;
  localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [N-1:0]     num;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   dvs;
  logic [CW-1:0]    cnt;
  logic             sign;
  logic             zero;
  logic             neg_dd;

  logic             accept;
  logic [WIDTH:0]   dd_ext, dv_ext;
  logic [WIDTH:0]   dd_mag, dv_mag;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             fits;
  logic [WIDTH-1:0] res_q;
  logic             res_ov;

  always_comb begin
    accept  = start && (state != CALC);
    dd_ext  = {dividend[WIDTH-1], dividend};
    dv_ext  = {divisor[WIDTH-1], divisor};
    dd_mag  = dd_ext[WIDTH] ? -dd_ext : dd_ext;
    dv_mag  = dv_ext[WIDTH] ? -dv_ext : dv_ext;
    rem_sh  = {rem, num[N-1]};
    fits    = rem_sh >= dvs;
    rem_sub = rem_sh - dvs;
  end

  // num doubles as the quotient: numerator bits shift out the top
  // while quotient bits shift in at the bottom.
  always_comb begin
    res_q  = sign ? -num[WIDTH-1:0] : num[WIDTH-1:0];
    res_ov = 1'b0;
    if (zero) begin
      res_q = neg_dd ? SAT_N : SAT_P;
    end else if (!sign && num > POS_LIM) begin
      res_q  = SAT_P;
      res_ov = 1'b1;
    end else if (sign && num > NEG_LIM) begin
      res_q  = SAT_N;
      res_ov = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = CALC;
      CALC: if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = accept ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num         <= '0;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      zero        <= 1'b0;
      neg_dd      <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      num    <= N'({dd_mag, {FRAC_BITS{1'b0}}});
      rem    <= '0;
      dvs    <= dv_mag;
      cnt    <= '0;
      sign   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      zero   <= (divisor == '0);
      neg_dd <= dividend[WIDTH-1];
    end else if (state == CALC) begin
      if (cnt != LAST) begin
        rem <= WIDTH'(fits ? rem_sub : rem_sh);
        num <= {num[N-2:0], fits};
        cnt <= cnt + 1'b1;
      end else begin
        quotient    <= res_q;
        overflow    <= res_ov;
        div_by_zero <= zero;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule
